// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: multicycle signed 32x32 multiply sequencer with HI/LO registers, MT writes and MF stall
module mult_hilo_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic {IDLE, CALC} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t             state;
    logic [3:0]         cnt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] p;

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product
    assign p = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};

    // HI/LO already hold the product in the done cycle, so only busy can stall a read
    assign stall = busy & rd_req;

    // Sequencer: capture operands, count out the settle window, then commit the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (mthi_we) hi <= wdata;
                if (mtlo_we) lo <= wdata;
                if (start) begin
                    a_q   <= op_a;
                    b_q   <= op_b;
                    cnt   <= CNT_INIT;
                    busy  <= 1'b1;
                    state <= CALC;
                end
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else begin
                hi    <= p[2*WIDTH-1:WIDTH];
                lo    <= p[WIDTH-1:0];
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end
endmodule
